// File: rtl/xaps_xrbus_out_arbiter.sv
// XR-BUS egress arbiter: round-robin with a high-priority class and a starvation
// override; the winning frame is registered into a valid/ready output stage.
module xaps_xrbus_out_arbiter #(
   parameter int N_SRC        = 3,
   parameter int FRAME_W      = 4096,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC-1:0]         src_valid,
   input  logic [N_SRC*FRAME_W-1:0] src_frame,
   output logic [N_SRC-1:0]         src_ready,
   input  logic [N_SRC-1:0]         prio_mask,
   output logic                     out_valid,
   output logic [FRAME_W-1:0]       out_frame,
   output logic [1:0]               out_src,
   input  logic                     out_ready,
   output logic [15:0]              frames_sent
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
   localparam logic [1:0]       PTR_RST = 2'(N_SRC - 1);

   logic                             out_valid_q, out_valid_d;
   logic [FRAME_W-1:0]               out_frame_q, out_frame_d;
   logic [1:0]                       out_src_q, out_src_d;
   logic [1:0]                       rr_ptr_q, rr_ptr_d;
   logic [15:0]                      frames_q, frames_d;
   logic [N_SRC-1:0][CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

   logic [N_SRC-1:0]   starving, prio_req, cand, gnt_oh;
   logic [1:0]         win_idx;
   logic               found;
   logic               load_en;
   logic [FRAME_W-1:0] win_frame;

   assign load_en = (!out_valid_q || out_ready) && (|src_valid);

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      starving = '0;
      for (int i = 0; i < N_SRC; i++)
         starving[i] = src_valid[i] && (wait_cnt_q[i] >= LIMIT);
      prio_req = src_valid & prio_mask;

      if (|starving)      cand = starving;
      else if (|prio_req) cand = prio_req;
      else                cand = src_valid;

      // Search begins one past the last winner and wraps, so the last winner
      // is considered last.
      gnt_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int k = 1; k <= N_SRC; k++) begin
         if (!found && cand[(int'(rr_ptr_q) + k) % N_SRC]) begin
            found                                  = 1'b1;
            gnt_oh[(int'(rr_ptr_q) + k) % N_SRC]   = 1'b1;
            win_idx                                = 2'((int'(rr_ptr_q) + k) % N_SRC);
         end
      end

      win_frame = '0;
      for (int i = 0; i < N_SRC; i++)
         if (gnt_oh[i]) win_frame = src_frame[i*FRAME_W +: FRAME_W];
   end

   assign src_ready = gnt_oh & {N_SRC{load_en}};

   always_comb begin
      out_valid_d = out_valid_q;
      out_frame_d = out_frame_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      frames_d    = frames_q;
      wait_cnt_d  = wait_cnt_q;

      if (load_en) begin
         out_valid_d = 1'b1;
         out_frame_d = win_frame;
         out_src_d   = win_idx;
         rr_ptr_d    = win_idx;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (out_valid_q && out_ready) frames_d = frames_q + 16'd1;

      // A source that drops its request forfeits accumulated waiting credit.
      for (int i = 0; i < N_SRC; i++) begin
         if (!src_valid[i])
            wait_cnt_d[i] = '0;
         else if (load_en) begin
            if (gnt_oh[i])                wait_cnt_d[i] = '0;
            else if (wait_cnt_q[i] < LIMIT) wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all
   // registers update together from pre-edge values. The frame register is
   // reset as well because the reset value of out_frame is architecturally visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_frame_q <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= PTR_RST;
         frames_q    <= '0;
         wait_cnt_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_frame_q <= out_frame_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
         frames_q    <= frames_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_frame   = out_frame_q;
   assign out_src     = out_src_q;
   assign frames_sent = frames_q;

endmodule

// File: tb/tb_xaps_xrbus_out_arbiter.sv
// Directed bench for xaps_xrbus_out_arbiter: single source, fairness,
// backpressure, starvation, reset mid-transfer and frame counter wrap.
module tb_xaps_xrbus_out_arbiter;

   localparam int N  = 3;
   localparam int FW = 4096;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    src_valid;
   logic [N*FW-1:0] src_frame;
   logic [N-1:0]    src_ready;
   logic [N-1:0]    prio_mask;
   logic            out_valid;
   logic [FW-1:0]   out_frame;
   logic [1:0]      out_src;
   logic            out_ready;
   logic [15:0]     frames_sent;

   int n_checks = 0;
   int n_fail   = 0;

   xaps_xrbus_out_arbiter #(.N_SRC(N), .FRAME_W(FW), .STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_valid   (src_valid),
      .src_frame   (src_frame),
      .src_ready   (src_ready),
      .prio_mask   (prio_mask),
      .out_valid   (out_valid),
      .out_frame   (out_frame),
      .out_src     (out_src),
      .out_ready   (out_ready),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   function automatic logic [FW-1:0] mk(int s, int tag);
      return {128{8'(s), 24'(tag)}};
   endfunction

   task automatic set_frames(int tag);
      for (int i = 0; i < N; i++) src_frame[i*FW +: FW] = mk(i, tag);
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_frame(string tag, logic [FW-1:0] obs, logic [FW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed low64 %h hi64 %h expected low64 %h hi64 %h",
                tag, obs[63:0], obs[FW-1 -: 64], exp[63:0], exp[FW-1 -: 64]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      src_valid = '0;
      prio_mask = '0;
      out_ready = 1'b0;
      set_frames(0);
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst frames_sent", 32'(frames_sent), 32'd0);
      check("rst out_src", 32'(out_src), 32'd0);
      check_frame("rst out_frame", out_frame, '0);
      tick();
      rst_n = 1'b1;
   endtask

   int t2_exp[6] = '{0, 1, 2, 0, 1, 2};
   int t4_exp[7] = '{0, 0, 0, 0, 1, 2, 0};

   initial begin
      rst_n = 1'b1;
      src_valid = '0;
      prio_mask = '0;
      out_ready = 1'b0;
      src_frame = '0;
      #2;
      do_reset();

      // T1 single source
      src_valid = 3'b010;
      out_ready = 1'b1;
      set_frames(7);
      #1;
      check("t1 src_ready", 32'(src_ready), 32'b010);
      tick();
      check("t1 out_valid", 32'(out_valid), 32'd1);
      check("t1 out_src", 32'(out_src), 32'd1);
      check_frame("t1 out_frame", out_frame, mk(1, 7));
      check("t1 frames before hs", 32'(frames_sent), 32'd0);
      src_valid = '0;
      tick();
      check("t1 frames_sent", 32'(frames_sent), 32'd1);
      check("t1 out_valid drop", 32'(out_valid), 32'd0);
      check("t1 out_src hold", 32'(out_src), 32'd1);

      // T2 fairness
      do_reset();
      src_valid = 3'b111;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_frames(k + 1);
         #1;
         check($sformatf("t2 src_ready %0d", k), 32'(src_ready), 32'(1 << t2_exp[k]));
         tick();
         check($sformatf("t2 out_src %0d", k), 32'(out_src), 32'(t2_exp[k]));
         check($sformatf("t2 out_valid %0d", k), 32'(out_valid), 32'd1);
         check_frame($sformatf("t2 out_frame %0d", k), out_frame, mk(t2_exp[k], k + 1));
      end
      check("t2 frames_sent", 32'(frames_sent), 32'd5);

      // T3 backpressure
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         set_frames(100 + c);
         #1;
         check($sformatf("t3 src_ready %0d", c), 32'(src_ready), 32'd0);
         tick();
         check($sformatf("t3 out_src %0d", c), 32'(out_src), 32'd2);
         check_frame($sformatf("t3 out_frame %0d", c), out_frame, mk(2, 6));
      end
      check("t3 frames held", 32'(frames_sent), 32'd5);
      out_ready = 1'b1;
      set_frames(200);
      #1;
      check("t3 release src_ready", 32'(src_ready), 32'b001);
      tick();
      check("t3 release out_src", 32'(out_src), 32'd0);
      check_frame("t3 release out_frame", out_frame, mk(0, 200));
      check("t3 frames_sent", 32'(frames_sent), 32'd6);

      // T4 starvation override with src 0 in the priority class
      do_reset();
      prio_mask = 3'b001;
      src_valid = 3'b111;
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         #1;
         check($sformatf("t4 src_ready %0d", k), 32'(src_ready), 32'(1 << t4_exp[k]));
         tick();
         check($sformatf("t4 out_src %0d", k), 32'(out_src), 32'(t4_exp[k]));
      end

      // Priority mask acts in the same cycle
      prio_mask = 3'b100;
      #1;
      check("prio same-cycle", 32'(src_ready), 32'b100);

      // T5 reset mid-transfer
      out_ready = 1'b0;
      tick();
      check("t5 full before reset", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5 out_valid async", 32'(out_valid), 32'd0);
      check("t5 frames async", 32'(frames_sent), 32'd0);
      tick();
      rst_n = 1'b1;
      prio_mask = '0;
      src_valid = 3'b111;
      out_ready = 1'b1;
      #1;
      check("t5 first grant", 32'(src_ready), 32'b001);

      // T6 wrap: load at first edge, then one handshake per edge
      tick();
      tick();
      check("t6 frames early", 32'(frames_sent), 32'd1);
      for (int m = 2; m < 65536; m++) tick();
      check("t6 frames ffff", 32'(frames_sent), 32'hFFFF);
      check("t6 out_valid", 32'(out_valid), 32'd1);
      tick();
      check("t6 frames wrap", 32'(frames_sent), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
